// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a single-port word RAM: sub-word stores
// are done as read-modify-write, loads are lane-selected and extended.
module mem_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_r_wn,
  output logic [ADDR_W-3:0] ram_address,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RSP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        bad;
  logic [4:0]  shift;
  logic [31:0] rword, ext, lane_mask, merged;

  assign bad = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane position of the addressed byte/half within the RAM word
  assign shift     = {addr_q[1:0], 3'b000};
  assign rword     = ram_data_out >> shift;
  assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
  assign merged    = (ram_data_out & ~lane_mask) | ((din_q << shift) & lane_mask);

  always_comb begin
    ext = ram_data_out;
    case (size_q)
      2'b00:   ext = {{24{rword[7]  & ~uns_q}}, rword[7:0]};
      2'b01:   ext = {{16{rword[15] & ~uns_q}}, rword[15:0]};
      default: ext = ram_data_out;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        din_d   = req_wdata;
        rdata_d = '0;
        err_d   = bad;
        if (bad)                           state_d = RSP;
        else if (req_we && req_size == 2'b10) state_d = WR;
        else                               state_d = RD;
      end
      RD:  state_d = MRG;
      MRG: begin
        if (we_q) begin
          din_d   = merged;
          state_d = WR;
        end else begin
          rdata_d = ext;
          state_d = RSP;
        end
      end
      WR:      state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write strobe decoded straight from the state flop: reset kills it at once
  assign ram_r_wn    = (state_q != WR);
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign ram_address = addr_q[ADDR_W-1:2];
  assign ram_data_in = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model, directed vector table, randomized ops
// against a byte-level reference memory, plus reset-abort and held-valid sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, ram_r_wn;
  logic [31:0] rsp_rdata, ram_data_in;
  logic [11:0] ram_address;
  bit   [31:0] ram_dout;
  bit   [31:0] ram [0:4095];
  bit   [7:0]  refm [0:16383];

  int n_chk = 0;
  int n_pass = 0;

  mem_access_ctrl #(.ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_r_wn(ram_r_wn), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_r_wn) ram[ram_address] <= ram_data_in;
    else           ram_dout <= ram[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: byte-addressed little-endian memory with the access rules
  function automatic void ref_op(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [13:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er,
                                 output int lat, output int nwr);
    int n;
    n  = 1 << sz;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd = 32'h0;
    if (er) begin
      lat = 1; nwr = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) refm[(int'(a) + i) & 16383] = wd[8*i +: 8];
      lat = (sz == 2'd2) ? 2 : 4; nwr = 1;
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = refm[(int'(a) + i) & 16383];
      if (!uns && n < 4 && rd[8*n-1])
        for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
      lat = 3; nwr = 0;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [13:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nwr);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nwr = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!ram_r_wn) nwr++;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        @(negedge clk);
        chk("rsp_single_cycle", {31'b0, rsp_valid}, 32'd0);
        chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [13:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
    int          elat;
    int          enwr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd, xrd, exp_d;
    logic        er, xer;
    int          lat, nwr, xlat, xnwr;
    int          nbad, nacc, npop, sgl_bad, dbad, extra, pend;
    logic        prev, cur_we;
    logic [31:0] q[$];
    logic [31:0] ram8;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 14'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        32'h000000DE, 1'b0, 3, 0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 14'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 14'h010, 32'h0,        32'h0000BEEF, 1'b0, 3, 0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 14'h011, 32'hFFFFFF55, 32'h0,        1'b0, 4, 1};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 14'h012, 32'hABCD1234, 32'h0,        1'b0, 4, 1};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        32'h123455EF, 1'b0, 3, 0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 14'h002, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 14'h001, 32'h77777777, 32'h0,        1'b1, 1, 0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 14'h000, 32'h0,        32'h0,        1'b1, 1, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_req_ready",   {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid",   {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata",   rsp_rdata, 32'd0);
    chk("rst_rsp_err",     {31'b0, rsp_err}, 32'd0);
    chk("rst_ram_r_wn",    {31'b0, ram_r_wn}, 32'd1);
    chk("rst_ram_address", {20'b0, ram_address}, 32'd0);
    chk("rst_ram_data_in", ram_data_in, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      ref_op(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, xrd, xer, xlat, xnwr);
      do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, rd, er, lat, nwr);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].erd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].eer});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
      chk($sformatf("vec%0d_writes", i), nwr, vecs[i].enwr);
    end
    chk("ram4_after_merge", ram[4], 32'h123455EF);

    // Randomized ops against the reference memory
    for (int i = 0; i < 40; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [13:0] a;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = 14'($urandom_range(0, 63));
      wd  = $urandom;
      ref_op(we, sz, uns, a, wd, xrd, xer, xlat, xnwr);
      do_req(we, sz, uns, a, wd, rd, er, lat, nwr);
      chk($sformatf("rnd%0d_rdata", i), rd, xrd);
      chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, xer});
      chk($sformatf("rnd%0d_latency", i), lat, xlat);
      chk($sformatf("rnd%0d_writes", i), nwr, xnwr);
    end

    // req_valid held high with alternating SW/LW at 0x100
    @(negedge clk);
    cur_we = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 14'h100; req_wdata = $urandom; req_valid = 1'b1;
    pend = 0; prev = 1'b0; nacc = 0; npop = 0; sgl_bad = 0; dbad = 0; extra = 0;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid) begin
        if (prev) sgl_bad++;
        if (q.size() == 0) extra++;
        else begin
          exp_d = q.pop_front();
          npop++;
          if (rsp_rdata !== exp_d || rsp_err !== 1'b0) dbad++;
        end
      end
      prev = rsp_valid;
      if (c >= 10) req_valid = 1'b0;
      else begin
        if (pend != 0) begin
          cur_we = ~cur_we; req_we = cur_we; req_wdata = $urandom; pend = 0;
        end
        if (req_ready) begin
          ref_op(req_we, req_size, req_unsigned, req_addr, req_wdata, xrd, xer, xlat, xnwr);
          q.push_back(xrd);
          nacc++; pend = 1;
        end
      end
    end
    chk("hold_accepts", nacc, 3);
    chk("hold_responses", npop, 3);
    chk("hold_single_cycle", sgl_bad, 0);
    chk("hold_data", dbad, 0);
    chk("hold_extra_rsp", extra + q.size(), 0);

    // Reset during the WR cycle of SW 0x020
    ram8 = ram[8];
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h020;
    req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wr", {31'b0, ram_r_wn}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_r_wn_async", {31'b0, ram_r_wn}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) nbad++;
    end
    chk("abort_no_rsp", nbad, 0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_ram8", ram[8], ram8);

    nbad = 0;
    for (int w = 0; w < 4096; w++)
      if (ram[w] !== {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]}) nbad++;
    chk("ram_image", nbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
